// File: rtl/pixel_scan_pkg.sv
// Shared definitions for the pixel scan scheduler: FSM states, CSR map and CTRL bits.
package pixel_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_WIDTH  = 2'd1;
    localparam logic [1:0] ADDR_HEIGHT = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int START = 0;
    localparam int CONT  = 1;
    localparam int ABORT = 2;

endpackage

// File: rtl/pixel_scan_csr.sv
// Avalon-MM register file for the scan scheduler: WIDTH/HEIGHT/CTRL.cont/sticky done,
// the combinational readdata mux and the start/abort write strobes.
module pixel_scan_csr
    import pixel_scan_pkg::*;
#(
    parameter int IDX_W  = 16,
    parameter int FCNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        address_i,
    input  logic              chipselect_i,
    input  logic              write_n_i,
    input  logic [31:0]       writedata_i,
    input  logic              busy_i,
    input  logic              set_done_i,
    input  logic [FCNT_W-1:0] fcnt_i,
    output logic [31:0]       readdata_o,
    output logic [IDX_W-1:0]  width_o,
    output logic [IDX_W-1:0]  height_o,
    output logic              cont_o,
    output logic              start_o,
    output logic              abort_o
);

    logic [IDX_W-1:0] width_q;
    logic [IDX_W-1:0] height_q;
    logic             cont_q;
    logic             done_q;
    logic             wr;
    logic             ctrl_wr;
    logic             unused_wdata;

    assign wr           = chipselect_i && !write_n_i;
    assign ctrl_wr      = wr && (address_i == ADDR_CTRL);
    assign abort_o      = ctrl_wr && writedata_i[ABORT];
    assign start_o      = ctrl_wr && writedata_i[START] && !writedata_i[ABORT];
    assign width_o      = width_q;
    assign height_o     = height_q;
    assign cont_o       = cont_q;
    assign unused_wdata = ^writedata_i[31:IDX_W];

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            width_q  <= '0;
            height_q <= '0;
            cont_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            if (ctrl_wr)
                cont_q <= writedata_i[CONT];
            // Frame geometry is frozen while a scan is in progress.
            if (wr && (address_i == ADDR_WIDTH) && !busy_i)
                width_q <= writedata_i[IDX_W-1:0];
            if (wr && (address_i == ADDR_HEIGHT) && !busy_i)
                height_q <= writedata_i[IDX_W-1:0];
            if (set_done_i)
                done_q <= 1'b1;
            else if (wr && (address_i == ADDR_STATUS))
                done_q <= 1'b0;
        end
    end

    // NOTE: the default assignment up front keeps this mux free of inferred latches.
    always_comb begin
        readdata_o = '0;
        case (address_i)
            ADDR_CTRL:   readdata_o[CONT] = cont_q;
            ADDR_WIDTH:  readdata_o[IDX_W-1:0] = width_q;
            ADDR_HEIGHT: readdata_o[IDX_W-1:0] = height_q;
            ADDR_STATUS: begin
                readdata_o[0]            = busy_i;
                readdata_o[1]            = done_q;
                readdata_o[8 +: FCNT_W]  = fcnt_i;
            end
            default:     readdata_o = '0;
        endcase
    end

endmodule

// File: rtl/pixel_scan_scheduler.sv
// Walks (pixel_index_in_row, row_index) over a WIDTH x HEIGHT frame, one index pair per
// valid/ready handshake, under control of the Nios CSR block.
module pixel_scan_scheduler
    import pixel_scan_pkg::*;
#(
    parameter int IDX_W  = 16,
    parameter int FCNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [IDX_W-1:0] pix_index,
    output logic [IDX_W-1:0] row_index,
    output logic             pix_valid,
    input  logic             pix_ready,
    output logic             line_start,
    output logic             frame_done,
    output logic             busy
);

    state_e            state_q;
    logic [IDX_W-1:0]  pix_q;
    logic [IDX_W-1:0]  row_q;
    logic              valid_q;
    logic              frame_done_q;
    logic [FCNT_W-1:0] fcnt_q;

    logic [IDX_W-1:0]  width;
    logic [IDX_W-1:0]  height;
    logic              cont;
    logic              start;
    logic              abort;
    logic              set_done;
    logic              accept;
    logic              last_pix;
    logic              last_row;
    logic              zero_size;

    pixel_scan_csr #(
        .IDX_W  (IDX_W),
        .FCNT_W (FCNT_W)
    ) u_csr (
        .clk          (clk),
        .reset        (reset),
        .address_i    (address),
        .chipselect_i (chipselect),
        .write_n_i    (write_n),
        .writedata_i  (writedata),
        .busy_i       (busy),
        .set_done_i   (set_done),
        .fcnt_i       (fcnt_q),
        .readdata_o   (readdata),
        .width_o      (width),
        .height_o     (height),
        .cont_o       (cont),
        .start_o      (start),
        .abort_o      (abort)
    );

    assign accept    = valid_q && pix_ready;
    assign last_pix  = (pix_q == width - IDX_W'(1));
    assign last_row  = (row_q == height - IDX_W'(1));
    assign zero_size = (width == '0) || (height == '0);

    // An abort landing on the last beat must not mark the frame done.
    assign set_done = !abort &&
                      (((state_q == IDLE) && start && zero_size) ||
                       ((state_q == RUN) && accept && last_pix && last_row));

    assign pix_index  = pix_q;
    assign row_index  = row_q;
    assign pix_valid  = valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q != IDLE);
    assign line_start = accept && (pix_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pix_q        <= '0;
            row_q        <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            fcnt_q       <= '0;
        end else begin
            frame_done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                valid_q <= 1'b0;
                pix_q   <= '0;
                row_q   <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start && !zero_size) begin
                            state_q <= RUN;
                            valid_q <= 1'b1;
                            pix_q   <= '0;
                            row_q   <= '0;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            if (last_pix) begin
                                pix_q <= '0;
                                if (last_row) begin
                                    row_q        <= '0;
                                    valid_q      <= 1'b0;
                                    frame_done_q <= 1'b1;
                                    fcnt_q       <= fcnt_q + FCNT_W'(1);
                                    state_q      <= FINISH;
                                end else begin
                                    row_q <= row_q + IDX_W'(1);
                                end
                            end else begin
                                pix_q <= pix_q + IDX_W'(1);
                            end
                        end
                    end
                    FINISH: begin
                        if (cont) begin
                            state_q <= RUN;
                            valid_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_scan_scheduler.sv
// Directed bench for pixel_scan_scheduler: frame walk, stalls, zero size, continuous mode,
// abort and mid-frame reset, with hand-computed expectations.
`timescale 1ns/1ps
module tb_pixel_scan_scheduler;
    import pixel_scan_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [15:0] pix_index;
    logic [15:0] row_index;
    logic        pix_valid;
    logic        pix_ready;
    logic        line_start;
    logic        frame_done;
    logic        busy;

    int checks = 0;
    int errors = 0;

    pixel_scan_scheduler #(.IDX_W(16), .FCNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pix_index  (pix_index),
        .row_index  (row_index),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .line_start (line_start),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Output vector layout: {pix_valid, line_start, frame_done, busy, pix_index, row_index}
    function automatic logic [35:0] outs();
        return {pix_valid, line_start, frame_done, busy, pix_index, row_index};
    endfunction

    function automatic logic [35:0] ev(input bit v, input bit ls, input bit fd, input bit bz,
                                       input int p, input int r);
        return {v, ls, fd, bz, 16'(p), 16'(r)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
    endtask

    task automatic release_bus();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
        drive_write(a, d);
        tick();
        release_bus();
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d          = readdata;
        chipselect = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pix_ready = 1'b0;
        address   = '0;
        release_bus();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        do_reset();
        checks++;
        if (outs() !== ev(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", outs(), ev(0, 0, 0, 0, 0, 0));
        end
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL reset_csr%0d: got %h expected %h", a, rd, 32'h0);
            end
        end
    endtask

    task automatic test_frame(input bit stall);
        logic [31:0] rd;
        logic [35:0] exp_v;
        do_reset();
        pix_ready = 1'b1;
        csr_write(ADDR_WIDTH, 32'd4);
        csr_write(ADDR_HEIGHT, 32'd2);
        csr_write(ADDR_CTRL, 32'h1);
        for (int b = 0; b < 8; b++) begin
            if (stall && b == 2) begin
                pix_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    #1;
                    checks++;
                    if (outs() !== ev(1, 0, 0, 1, 2, 0)) begin
                        errors++;
                        $display("FAIL stall_hold%0d: got %h expected %h", s, outs(), ev(1, 0, 0, 1, 2, 0));
                    end
                    tick();
                end
                pix_ready = 1'b1;
            end
            #1;
            exp_v = ev(1, (b % 4) == 0, 0, 1, b % 4, b / 4);
            checks++;
            if (outs() !== exp_v) begin
                errors++;
                $display("FAIL frame_beat%0d: got %h expected %h", b, outs(), exp_v);
            end
            tick();
        end
        checks++;
        if (outs() !== ev(0, 0, 1, 1, 0, 0)) begin
            errors++;
            $display("FAIL frame_done_pulse: got %h expected %h", outs(), ev(0, 0, 1, 1, 0, 0));
        end
        tick();
        checks++;
        if (outs() !== ev(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL frame_idle: got %h expected %h", outs(), ev(0, 0, 0, 0, 0, 0));
        end
        csr_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h102) begin
            errors++;
            $display("FAIL frame_status: got %h expected %h", rd, 32'h102);
        end
    endtask

    task automatic test_zero_size();
        logic [31:0] rd;
        do_reset();
        pix_ready = 1'b1;
        csr_write(ADDR_HEIGHT, 32'd2);
        csr_write(ADDR_CTRL, 32'h1);
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (outs() !== ev(0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL zero_idle%0d: got %h expected %h", c, outs(), ev(0, 0, 0, 0, 0, 0));
            end
            tick();
        end
        csr_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h2) begin
            errors++;
            $display("FAIL zero_done: got %h expected %h", rd, 32'h2);
        end
        tick();
        csr_write(ADDR_STATUS, 32'h0);
        csr_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL zero_done_clear: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_continuous();
        logic [31:0] rd;
        do_reset();
        pix_ready = 1'b1;
        csr_write(ADDR_WIDTH, 32'd2);
        csr_write(ADDR_HEIGHT, 32'd1);
        csr_write(ADDR_CTRL, 32'h3);
        for (int f = 0; f < 3; f++) begin
            #1;
            checks++;
            if (outs() !== ev(1, 1, 0, 1, 0, 0)) begin
                errors++;
                $display("FAIL cont_f%0d_beat0: got %h expected %h", f, outs(), ev(1, 1, 0, 1, 0, 0));
            end
            tick();
            if (f == 0) drive_write(ADDR_WIDTH, 32'd5);
            if (f == 2) drive_write(ADDR_CTRL, 32'h0);
            #1;
            checks++;
            if (outs() !== ev(1, 0, 0, 1, 1, 0)) begin
                errors++;
                $display("FAIL cont_f%0d_beat1: got %h expected %h", f, outs(), ev(1, 0, 0, 1, 1, 0));
            end
            tick();
            release_bus();
            checks++;
            if (outs() !== ev(0, 0, 1, 1, 0, 0)) begin
                errors++;
                $display("FAIL cont_f%0d_done: got %h expected %h", f, outs(), ev(0, 0, 1, 1, 0, 0));
            end
            tick();
        end
        checks++;
        if (outs() !== ev(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL cont_stop: got %h expected %h", outs(), ev(0, 0, 0, 0, 0, 0));
        end
        csr_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h302) begin
            errors++;
            $display("FAIL cont_status: got %h expected %h", rd, 32'h302);
        end
        csr_read(ADDR_WIDTH, rd);
        checks++;
        if (rd !== 32'd2) begin
            errors++;
            $display("FAIL cont_width_locked: got %h expected %h", rd, 32'd2);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd;
        do_reset();
        pix_ready = 1'b1;
        csr_write(ADDR_WIDTH, 32'd4);
        csr_write(ADDR_HEIGHT, 32'd2);
        csr_write(ADDR_CTRL, 32'h3);
        repeat (5) tick();
        checks++;
        if (outs() !== ev(1, 0, 0, 1, 1, 1)) begin
            errors++;
            $display("FAIL abort_pre: got %h expected %h", outs(), ev(1, 0, 0, 1, 1, 1));
        end
        csr_write(ADDR_CTRL, 32'h4);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (outs() !== ev(0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL abort_mid%0d: got %h expected %h", c, outs(), ev(0, 0, 0, 0, 0, 0));
            end
            tick();
        end
        csr_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL abort_status: got %h expected %h", rd, 32'h0);
        end
        tick();
        csr_write(ADDR_CTRL, 32'h5);
        checks++;
        if (outs() !== ev(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL abort_beats_start: got %h expected %h", outs(), ev(0, 0, 0, 0, 0, 0));
        end
        csr_write(ADDR_CTRL, 32'h1);
        repeat (7) tick();
        checks++;
        if (outs() !== ev(1, 0, 0, 1, 3, 1)) begin
            errors++;
            $display("FAIL abort_last_pre: got %h expected %h", outs(), ev(1, 0, 0, 1, 3, 1));
        end
        csr_write(ADDR_CTRL, 32'h4);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (outs() !== ev(0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL abort_last%0d: got %h expected %h", c, outs(), ev(0, 0, 0, 0, 0, 0));
            end
            tick();
        end
        csr_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL abort_last_status: got %h expected %h", rd, 32'h0);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] rd;
        do_reset();
        pix_ready = 1'b1;
        csr_write(ADDR_WIDTH, 32'd3);
        csr_write(ADDR_HEIGHT, 32'd2);
        csr_write(ADDR_CTRL, 32'h3);
        repeat (9) tick();
        csr_read(ADDR_STATUS, rd);
        checks++;
        if (rd !== 32'h103) begin
            errors++;
            $display("FAIL rst_pre_status: got %h expected %h", rd, 32'h103);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (outs() !== ev(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL rst_outputs: got %h expected %h", outs(), ev(0, 0, 0, 0, 0, 0));
        end
        for (int a = 0; a < 4; a++) begin
            csr_read(2'(a), rd);
            checks++;
            if (rd !== 32'h0) begin
                errors++;
                $display("FAIL rst_csr%0d: got %h expected %h", a, rd, 32'h0);
            end
        end
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (outs() !== ev(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL rst_stays_idle: got %h expected %h", outs(), ev(0, 0, 0, 0, 0, 0));
        end
    endtask

    initial begin
        test_reset();
        test_frame(1'b0);
        test_frame(1'b1);
        test_zero_size();
        test_continuous();
        test_abort();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
